// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, legality check, FSM encoding and entry layout shared by the ALU driver
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam int CMD_W = 68;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT};
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous first-word-fall-through command FIFO
// ports: clk, rst, push/din write side, pop/dout read side (dout valid while !empty), full, empty
module alu_cmd_fifo import alu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = CMD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/alu_driver.sv
// alu_driver: queues ALU commands, issues them one at a time to a registered ALU and returns tagged results
// ports: in_* command valid/ready, out_* tagged result valid/ready, alu_* ALU connection, busy, done_cnt
module alu_driver import alu_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             alu_rst_n,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  output logic             busy,
  output logic [15:0]      done_cnt
);
  state_t state;
  logic [2:0] cnt;
  logic [TAG_W-1:0] tag_cnt;
  logic [CMD_W-1:0] head;
  logic full, empty, push, pop, hs;
  logic [3:0] head_op;
  assign in_ready = !full && !rst;
  assign push = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  // a new command leaves the FIFO either from IDLE or on the edge that retires the previous result
  assign pop = !rst && !empty && (state == ST_IDLE || (state == ST_DONE && hs));
  assign head_op = head[67:64];
  assign busy = state != ST_IDLE || !empty;
  alu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({in_op, in_src2, in_src1}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      tag_cnt <= '0;
      done_cnt <= '0;
      alu_rst_n <= 1'b0;
      alu_src1 <= '0;
      alu_src2 <= '0;
      alu_ctrl <= '0;
      out_valid <= 1'b0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_cout <= 1'b0;
      out_ovf <= 1'b0;
      out_err <= 1'b0;
      out_tag <= '0;
    end else begin
      alu_rst_n <= 1'b1;
      if (hs) done_cnt <= done_cnt + 16'd1;
      if (pop) begin
        tag_cnt <= tag_cnt + TAG_W'(1);
        out_tag <= tag_cnt;
        if (is_legal_op(head_op)) begin
          alu_src1 <= head[31:0];
          alu_src2 <= head[63:32];
          alu_ctrl <= head_op;
          cnt <= '0;
          out_valid <= 1'b0;
          out_err <= 1'b0;
          state <= ST_WAIT;
        end else begin
          // illegal opcodes never reach the ALU; its inputs keep the previous command
          out_result <= '0;
          out_zero <= 1'b0;
          out_cout <= 1'b0;
          out_ovf <= 1'b0;
          out_err <= 1'b1;
          out_valid <= 1'b1;
          state <= ST_DONE;
        end
      end else if (state == ST_WAIT) begin
        if (cnt == 3'(ALU_LAT)) begin
          out_result <= alu_result;
          out_zero <= alu_zero;
          out_cout <= alu_cout;
          out_ovf <= alu_ovf;
          out_err <= 1'b0;
          out_valid <= 1'b1;
          state <= ST_DONE;
        end else cnt <= cnt + 3'd1;
      end else if (hs) begin
        out_valid <= 1'b0;
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed scoreboard bench for alu_driver with a behavioural registered ALU on the alu_* ports
module tb_alu_driver;
  import alu_pkg::*;
  typedef struct packed {logic [31:0] r; logic z; logic c; logic v;} alu_out_t;
  typedef struct packed {logic [31:0] r; logic z; logic c; logic v; logic e; logic [7:0] t;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic [3:0] in_op = '0;
  logic in_ready, out_valid, out_zero, out_cout, out_ovf, out_err, alu_rst_n, busy;
  logic alu_zero, alu_cout, alu_ovf;
  logic [31:0] out_result, alu_src1, alu_src2, alu_result;
  logic [3:0] alu_ctrl;
  logic [7:0] out_tag;
  logic [15:0] done_cnt;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t sb[$];
  logic [7:0] exp_tag = '0;
  alu_out_t alu_q;
  exp_t obs, snap;
  logic held = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_driver #(.FIFO_DEPTH(4), .ALU_LAT(1), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_err(out_err), .out_tag(out_tag),
    .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .busy(busy), .done_cnt(done_cnt)
  );
  function automatic alu_out_t alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] s;
    alu_out_t o;
    o = '0;
    case (op)
      OP_AND: o.r = a & b;
      OP_OR:  o.r = a | b;
      OP_NOR: o.r = ~(a | b);
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      OP_SLT: o.r = {31'd0, $signed(a) < $signed(b)};
      default: o.r = '0;
    endcase
    o.z = o.r == '0;
    return o;
  endfunction
  always @(posedge clk) alu_q <= alu_rst_n ? alu_model(alu_src1, alu_src2, alu_ctrl) : '0;
  assign alu_result = alu_q.r;
  assign alu_zero = alu_q.z;
  assign alu_cout = alu_q.c;
  assign alu_ovf = alu_q.v;
  assign obs = {out_result, out_zero, out_cout, out_ovf, out_err, out_tag};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", obs, snap);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_result", obs, 0);
        else check("result", obs, sb.pop_front());
      end
      held = out_valid && !out_ready;
      snap = obs;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int n = 0;
    alu_out_t m;
    exp_t e;
    in_valid = 1'b1;
    in_src1 = a;
    in_src2 = b;
    in_op = op;
    while (!in_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (!in_ready) check("push_timeout", in_ready, 1);
    else begin
      m = alu_model(a, b, op);
      e = '0;
      e.t = exp_tag;
      if (is_legal_op(op)) begin
        e.r = m.r;
        e.z = m.z;
        e.c = m.c;
        e.v = m.v;
      end else e.e = 1'b1;
      sb.push_back(e);
      exp_tag++;
    end
    tick(1);
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", obs, 0);
    check("rst_alu_in", {alu_src1, alu_src2, alu_ctrl}, 0);
    check("rst_alu_rst_n", alu_rst_n, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    sb.delete();
    exp_tag = '0;
    rst = 1'b0;
    tick(1);
    check("rst_release", {alu_rst_n, in_ready}, 2'b11);
  endtask
  task automatic wait_out(output int t);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick(1);
      n++;
    end
    check("wait_out_valid", out_valid, 1);
    t = cyc;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    tick(1);
    check("drain_idle", busy, 0);
  endtask
  initial begin
    int t1, t2, n;
    logic [31:0] keep;
    do_reset();
    out_ready = 1'b0;
    push(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
    tick(2);
    check("lat_k2", out_valid, 0);
    tick(1);
    check("lat_k3", out_valid, 1);
    out_ready = 1'b1;
    drain();
    do_reset();
    out_ready = 1'b1;
    push(32'd5, 32'd5, OP_SUB);
    push(32'hFFFF_FFFF, 32'h0000_0001, OP_SLT);
    wait_out(t1);
    tick(1);
    check("b2b_gap_low", out_valid, 0);
    wait_out(t2);
    check("b2b_period", t2 - t1, 3);
    drain();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h100 * i + 32'd1, 32'(i + 3), i[0] ? OP_ADD : OP_OR);
    check("full_ready", in_ready, 0);
    check("full_valid", out_valid, 1);
    keep = out_result;
    tick(10);
    check("hold10_result", out_result, keep);
    check("hold10_tag", out_tag, 0);
    out_ready = 1'b1;
    drain();
    check("drain5_done_cnt", done_cnt, 5);
    do_reset();
    out_ready = 1'b1;
    push(32'hF0F0_1234, 32'h0FF0_FFFF, OP_AND);
    push(32'h0000_DEAD, 32'h0000_BEEF, 4'b1111);
    push(32'h1234_5678, 32'hFFFF_0000, OP_AND);
    n = 0;
    while (!(out_valid && out_err) && n < 100) begin
      tick(1);
      n++;
    end
    check("err_seen", {out_valid, out_err}, 2'b11);
    check("err_alu_held", {alu_src1, alu_src2, alu_ctrl}, {32'hF0F0_1234, 32'h0FF0_FFFF, OP_AND});
    drain();
    check("err_done_cnt", done_cnt, 3);
    do_reset();
    out_ready = 1'b1;
    push(32'd1, 32'd2, OP_ADD);
    tick(1);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick(1);
    check("abort_state", {out_valid, busy, alu_rst_n, in_ready}, 4'b0000);
    sb.delete();
    exp_tag = '0;
    rst = 1'b0;
    tick(6);
    check("abort_no_result", {out_valid, busy, done_cnt}, 18'd0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) push(32'(i), ~32'(i * 7), OP_NOR);
    drain();
    check("wrap_done_cnt", done_cnt, 260);
    check("wrap_last_tag", out_tag, 8'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Command-side counterpart of the team's registered 32-bit ALU. Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU's src1/src2/ALU_control inputs, holds the operands stable for the ALU's registered latency, then captures result/zero/cout/overflow.
- Returns the captured result on a valid/ready output interface with a sequence tag.
- Sits between the datapath/testbench sequencer and the ALU instance.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- ALU_LAT, 1, clock edges from the ALU sampling the operands to its registered outputs being stable; range 1..7.
- TAG_W, 8, width of the sequence tag.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command FIFO not full.
- in_src1  in  32  operand 1.
- in_src2  in  32  operand 2.
- in_op  in  4  ALU_control code.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  captured ALU result.
- out_zero  out  1  captured zero flag.
- out_cout  out  1  captured carry out.
- out_ovf  out  1  captured overflow flag.
- out_err  out  1  command had an illegal opcode; ALU bypassed.
- out_tag  out  TAG_W  sequence number of the command.
- alu_rst_n  out  1  registered ~rst, drives the ALU's negative reset.
- alu_src1  out  32  to ALU src1.
- alu_src2  out  32  to ALU src2.
- alu_ctrl  out  4  to ALU ALU_control.
- alu_result  in  32  from ALU result.
- alu_zero  in  1  from ALU zero.
- alu_cout  in  1  from ALU cout.
- alu_ovf  in  1  from ALU overflow.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- done_cnt  out  16  results accepted by the consumer; wraps at 16 bits.

Behaviour:
- Reset (rst high at an edge):
  - out_valid=0, out_result=0, out flags=0, out_tag=0.
  - alu_src1/src2=0, alu_ctrl=4'b0000, alu_rst_n=0.
  - FIFO emptied, tag counter=0, done_cnt=0, FSM=IDLE.
  - in_ready=0 while rst is high.
  - A reset in the middle of an operation aborts it; no result is produced.
- Legal opcodes are 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT. All other codes are illegal.
- Push: an entry is written when in_valid&&in_ready. in_ready = !full (combinational).
  - A push and a pop in the same cycle with the FIFO full is not allowed, because in_ready is low.
  - A push and a pop in the same cycle with the FIFO non-full changes the count by 0.
- Tag: the tag counter is assigned at pop, increments per popped command, and wraps modulo 2^TAG_W.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, FIFO non-empty: pop; load alu_src1/src2/ctrl from the entry; latch tag.
    - Legal op: cnt=0, go to WAIT.
    - Illegal op: out_result=0, flags=0, out_err=1, out_valid=1, go to DONE. ALU registers are left unchanged.
  - WAIT: alu_* held stable.
    - cnt!=ALU_LAT: cnt++ each edge.
    - cnt==ALU_LAT at an edge: capture alu_result/zero/cout/ovf into out_*, out_err=0, out_valid=1, go to DONE.
  - DONE: out_* held until out_valid&&out_ready. On that edge done_cnt++.
    - FIFO non-empty: pop the next command in the same edge (same rules as IDLE). This gives back-to-back issue.
    - FIFO empty: out_valid=0, go to IDLE.
- Latency: with FIFO empty and FSM IDLE, a push at edge k gives out_valid=1 after edge k+2+ALU_LAT.
- Throughput: with out_ready held high, one result per ALU_LAT+2 cycles. An illegal op takes 1 cycle in DONE.
- out_valid never drops without a handshake. out_* do not change while out_valid&&!out_ready.
- busy = (FSM!=IDLE) || !empty.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT;
  - function is_legal_op;
  - FSM state encoding.
- Sub-module alu_cmd_fifo holds the 68-bit entries {op,src2,src1}: synchronous, first-word-fall-through, with full/empty outputs.
- The top level contains the FSM, latency counter, capture registers and counters.
- The test bench instantiates the team ALU on the alu_* ports.

Test Plan:
- Reset then single ADD 0x7FFFFFFF+0x00000001, ALU_LAT=1 -> out_valid at edge k+3; result 0x80000000, ovf=1, cout=0, zero=0, tag=0.
- SUB 5-5 followed by SLT 0xFFFFFFFF,0x00000001, out_ready high -> result 0 zero=1 cout=1 tag=0; then result 1 tag=1; second out_valid 3 cycles after first.
- Push 5 commands back-to-back with out_ready=0, FIFO_DEPTH=4 -> in_ready low after 4 stored plus 1 in flight; first result held stable for 10 cycles; releasing out_ready drains all 5 in order, done_cnt=5.
- Illegal op 4'b1111 between two ANDs -> out_err=1, result 0, ALU inputs unchanged; neighbouring ANDs correct with err=0; tags 0,1,2.
- Assert rst during WAIT -> next edge out_valid=0, busy=0, FIFO empty, alu_rst_n=0; the aborted command never appears.
- Push 260 NOR commands -> tags wrap 255->0; done_cnt=260.
